mux_sel_serializer: RTL

- Upstream control stage for n_1_mux_rtl. Accepts a parallel 2^N-bit word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the mux select line one index per accepted beat.
- Returns the mux's 1-bit output as a serial stream with valid/ready/last.
- This turns the combinational N:1 mux into a flow-controlled parallel-to-serial converter.

---
 rtl/mux_pkg.sv | 17 +
 rtl/n_1_mux_rtl.sv | 12 +
 rtl/sel_counter.sv | 28 ++
 rtl/mux_sel_serializer.sv | 79 +++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and select-range helper for the mux serializer
package mux_pkg;

    localparam int N_DEFAULT = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Ascending order starts at 0 and ends at x-1; descending is the mirror.
    function automatic int unsigned sel_bound(input bit msb_first, input bit want_end,
                                              input int unsigned x);
        return (msb_first ^ want_end) ? x - 1 : 0;
    endfunction

endpackage

// File: rtl/n_1_mux_rtl.sv
// rtl/n_1_mux_rtl.sv - combinational 2**N:1 bit multiplexer
module n_1_mux_rtl #(
    parameter int N = 3
) (
    input  logic [2**N-1:0] data_in,
    input  logic [N-1:0]    s_line,
    output logic            out
);

    assign out = data_in[s_line];

endmodule

// File: rtl/sel_counter.sv
// rtl/sel_counter.sv - N-bit up/down select counter with load and terminal flag
module sel_counter #(
    parameter int          N      = 3,
    parameter bit          DOWN   = 1'b0,
    parameter logic [N-1:0] START = '0,
    parameter logic [N-1:0] TERM  = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    output logic [N-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= START;
        end else if (en) begin
            count <= DOWN ? count - 1'b1 : count + 1'b1;
        end
    end

    assign tc = (count == TERM);

endmodule

// File: rtl/mux_sel_serializer.sv
// rtl/mux_sel_serializer.sv - drives an N:1 mux as a flow-controlled parallel-to-serial converter
import mux_pkg::*;

module mux_sel_serializer #(
    parameter int N         = N_DEFAULT,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [2**N-1:0] load_data,
    output logic [2**N-1:0] data_in,
    output logic [N-1:0]    s_line,
    input  logic            mux_out,
    output logic            ser_valid,
    input  logic            ser_ready,
    output logic            ser_data,
    output logic            ser_last,
    output logic            busy
);

    localparam int           X         = 2**N;
    localparam logic [N-1:0] START_SEL = N'(sel_bound(MSB_FIRST, 1'b0, X));
    localparam logic [N-1:0] END_SEL   = N'(sel_bound(MSB_FIRST, 1'b1, X));

    state_t state, state_nxt;
    logic   load_fire;
    logic   beat;
    logic   at_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            data_in <= '0;
        end else begin
            state <= state_nxt;
            if (load_fire) begin
                data_in <= load_data;
            end
        end
    end

    // A word may be accepted in the same cycle the previous one emits its last bit.
    always_comb begin
        state_nxt  = state;
        busy       = (state == SHIFT);
        ser_valid  = (state == SHIFT);
        ser_last   = (state == SHIFT) && at_end;
        ser_data   = mux_out;
        load_ready = (state == IDLE) || (ser_last && ser_ready);
        load_fire  = load_valid && load_ready;
        beat       = ser_valid && ser_ready;
        case (state)
            IDLE: begin
                if (load_fire) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (beat && ser_last) state_nxt = load_fire ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    sel_counter #(
        .N     (N),
        .DOWN  (MSB_FIRST),
        .START (START_SEL),
        .TERM  (END_SEL)
    ) u_sel_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (load_fire),
        .en    (beat && !ser_last),
        .count (s_line),
        .tc    (at_end)
    );

endmodule
